// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: shared constants and types for the seven-segment scanner.
//   NUM_DIGITS  number of scanned digits
//   SEG_BLANK   all segments off (active-low)
//   AN_OFF      all anodes off (active-low)
//   GLYPHS      active-low {g,f,e,d,c,b,a} patterns, indexed by hex value
//   disp_t      one frame's worth of display content
package seg7_scan_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'hF;

    // Element [15] comes first in the concatenation, so the list reads F..0.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] digit;
        logic [NUM_DIGITS-1:0]      dp;
        logic [NUM_DIGITS-1:0]      blank;
    } disp_t;

endpackage

// File: rtl/seg7_scan_hex.sv
// hex_to_7seg: combinational hex digit to active-low seven-segment glyph.
//   hex  in  4  digit value 0..F
//   seg  out 7  {g,f,e,d,c,b,a}, active-low
module hex_to_7seg
    import seg7_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = GLYPHS[hex];

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a 4-digit common-anode display.
// A write lands in a shadow register and is copied to the live display
// only on a frame boundary, so a frame never mixes old and new digits.
//   clk       in   1   system clock
//   reset     in   1   synchronous, active-high
//   wr_valid  in   1   write request
//   wr_ready  out  1   high when no write is waiting for a frame boundary
//   data      in   16  four hex digits, data[3:0] is digit0 (an[0])
//   dp_in     in   4   decimal point per digit, 1 = lit
//   blank     in   4   per-digit blank, 1 = never lit
//   an        out  4   anode enables, active-low
//   seg       out  7   segments {g..a}, active-low
//   dp        out  1   decimal point, active-low
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int GHOST    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pcnt;
    logic [1:0]    idx;
    disp_t         disp;
    disp_t         shadow;
    logic          pending;

    logic          tick;
    logic          boundary;
    logic          accept;
    logic [6:0]    glyph;

    assign tick     = (pcnt == PW'(PRESCALE - 1));
    assign boundary = tick && (idx == 2'd3);
    assign wr_ready = ~pending;
    assign accept   = wr_valid && ~pending;

    hex_to_7seg u_dec (
        .hex (disp.digit[idx]),
        .seg (glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt    <= '0;
            idx     <= '0;
            disp    <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            an      <= AN_OFF;
            seg     <= SEG_BLANK;
            dp      <= 1'b1;
        end else begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
            if (tick)
                idx <= idx + 2'd1;

            // accept needs pending==0 and the copy needs pending==1, so a
            // write arriving on a boundary edge only fills the shadow.
            if (boundary && pending) begin
                disp    <= shadow;
                pending <= 1'b0;
            end
            if (accept) begin
                shadow  <= {data, dp_in, blank};
                pending <= 1'b1;
            end

            // The first GHOST clocks of each slot keep every anode off so the
            // previous digit's segments never flash on the new anode.
            if ((pcnt >= PW'(GHOST)) && !disp.blank[idx])
                an <= ~(4'b0001 << idx);
            else
                an <= AN_OFF;
            seg <= glyph;
            dp  <= ~disp.dp[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seg7_scan #(.PRESCALE(4), .GHOST(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .data     (data),
        .dp_in    (dp_in),
        .blank    (blank),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wv;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       rdy;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: inputs were set at the previous negedge; outputs sampled at this negedge.
    task automatic step();
        @(posedge clk);
        if (reset) cyc = 0;
        else       cyc++;
        @(negedge clk);
    endtask

    task automatic go_to(input int t);
        int n = 0;
        while ((cyc % 16) != t && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL go_to: slot %0d not reached, got %0d", t, cyc % 16);
        end
    endtask

    task automatic write(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        wr_valid = 1'b1; data = d; dp_in = p; blank = b;
        chk("wr_ready_before_write", wr_ready, 1'b1);
        step();
        wr_valid = 1'b0;
        chk("wr_ready_after_write", wr_ready, 1'b0);
    endtask

    initial begin
        // 1: reset and the idle scan walk (ghost clock shows F)
        tbl[0]  = '{0, 4'hF, 7'h7F, 1, 1};
        tbl[1]  = '{0, 4'hF, 7'h40, 1, 1};
        tbl[2]  = '{0, 4'hE, 7'h40, 1, 1};
        tbl[3]  = '{0, 4'hE, 7'h40, 1, 1};
        tbl[4]  = '{0, 4'hE, 7'h40, 1, 1};
        tbl[5]  = '{0, 4'hF, 7'h40, 1, 1};
        tbl[6]  = '{0, 4'hD, 7'h40, 1, 1};
        tbl[7]  = '{0, 4'hD, 7'h40, 1, 1};
        tbl[8]  = '{0, 4'hD, 7'h40, 1, 1};
        tbl[9]  = '{0, 4'hF, 7'h40, 1, 1};
        tbl[10] = '{0, 4'hB, 7'h40, 1, 1};
        tbl[11] = '{0, 4'hB, 7'h40, 1, 1};
        tbl[12] = '{0, 4'hB, 7'h40, 1, 1};
        tbl[13] = '{0, 4'hF, 7'h40, 1, 1};
        tbl[14] = '{0, 4'h7, 7'h40, 1, 1};
        tbl[15] = '{0, 4'h7, 7'h40, 1, 1};
        tbl[16] = '{0, 4'h7, 7'h40, 1, 1};

        repeat (3) step();
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_dp", dp, 1'b1);
        chk("reset_rdy", wr_ready, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i > 0) step();
            wr_valid = tbl[i].wv;
            chk($sformatf("walk_an[%0d]", i), an, tbl[i].an);
            chk($sformatf("walk_seg[%0d]", i), seg, tbl[i].seg);
            chk($sformatf("walk_dp[%0d]", i), dp, tbl[i].dp);
            chk($sformatf("walk_rdy[%0d]", i), wr_ready, tbl[i].rdy);
        end

        // 2: 1234 waits for the frame boundary
        write(16'h1234, 4'h0, 4'h0);
        go_to(15);
        chk("t2_rdy_pre_boundary", wr_ready, 1'b0);
        chk("t2_old_seg", seg, 7'h40);
        step();
        chk("t2_rdy_post_boundary", wr_ready, 1'b1);
        chk("t2_lag_seg", seg, 7'h40);
        step();
        chk("t2_new_seg0", seg, 7'h19);
        go_to(2);
        chk("t2_d0_an", an, 4'hE);
        chk("t2_d0_seg", seg, 7'h19);
        chk("t2_d0_dp", dp, 1'b1);
        go_to(14);
        chk("t2_d3_an", an, 4'h7);
        chk("t2_d3_seg", seg, 7'h79);
        chk("t2_d3_dp", dp, 1'b1);

        // 3: ABCD accepted, FFFF stalls behind it for one frame
        wr_valid = 1'b1; data = 16'hABCD;
        step();
        data = 16'hFFFF;
        chk("t3_stall_rdy", wr_ready, 1'b0);
        step();
        chk("t3_rdy_after_boundary", wr_ready, 1'b1);
        step();
        wr_valid = 1'b0;
        chk("t3_ffff_taken", wr_ready, 1'b0);
        go_to(2);
        chk("t3_abcd_an", an, 4'hE);
        chk("t3_abcd_seg0", seg, 7'h21);
        go_to(14);
        chk("t3_abcd_seg3", seg, 7'h08);
        go_to(2);
        chk("t3_ffff_seg0", seg, 7'h0E);
        chk("t3_ffff_an", an, 4'hE);

        // 4: write on the boundary edge lands one full frame later
        go_to(15);
        write(16'h5678, 4'h0, 4'h0);
        go_to(2);
        chk("t4_still_ffff", seg, 7'h0E);
        go_to(15);
        chk("t4_rdy_pending", wr_ready, 1'b0);
        step();
        chk("t4_rdy_release", wr_ready, 1'b1);
        go_to(2);
        chk("t4_new_seg0", seg, 7'h00);
        chk("t4_new_an", an, 4'hE);

        // 5: digit3 blanked, only digit0's decimal point lit
        write(16'h9876, 4'b0001, 4'b1000);
        go_to(0);
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("t5_an3[%0d]", k), an[3], 1'b1);
            chk($sformatf("t5_dp[%0d]", k), dp, (k < 4) ? 1'b0 : 1'b1);
            if (k >= 12) chk($sformatf("t5_an_off[%0d]", k), an, 4'hF);
            if (k == 2)  chk("t5_seg0", seg, 7'h02);
        end

        // 6: reset mid-slot discards the pending write
        write(16'h2222, 4'h0, 4'h0);
        go_to(9);
        reset = 1'b1;
        step();
        chk("t6_reset_an", an, 4'hF);
        chk("t6_reset_seg", seg, 7'h7F);
        chk("t6_reset_rdy", wr_ready, 1'b1);
        reset = 1'b0;
        step();
        chk("t6_ghost_an", an, 4'hF);
        step();
        chk("t6_d0_an", an, 4'hE);
        chk("t6_d0_seg", seg, 7'h40);
        go_to(14);
        chk("t6_d3_an", an, 4'h7);
        chk("t6_d3_seg", seg, 7'h40);
        go_to(2);
        chk("t6_lost_seg", seg, 7'h40);
        chk("t6_lost_an", an, 4'hE);
        chk("t6_lost_dp", dp, 1'b1);
        chk("t6_lost_rdy", wr_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
